// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - Issue/writeback sequencer driving an external 8-bit ALU.
// Owns the 4x8 register file and carry flag; one instruction per three cycles.
module alu_issue_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [7:0]  alu_op1,
  output logic [7:0]  alu_op2,
  output logic [2:0]  alu_sel,
  input  logic [7:0]  alu_out,
  input  logic        alu_co,
  output logic        done,
  output logic [7:0]  result,
  output logic        carry,
  input  logic [1:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] rf [4];
  logic [1:0] rd_q;
  logic       accept;

  logic [2:0] f_sel;
  logic [1:0] f_rd;
  logic [1:0] f_rs;
  logic       f_imm;
  logic [7:0] f_imm8;
  logic [1:0] f_rt;
  logic [7:0] op1;
  logic [7:0] op2;

  assign f_sel  = instr[15:13];
  assign f_rd   = instr[12:11];
  assign f_rs   = instr[10:9];
  assign f_imm  = instr[8];
  assign f_imm8 = instr[7:0];
  assign f_rt   = instr[1:0];

  // Load-immediate feeds imm8 on both operands so the ALU passes it through.
  assign op1 = (f_imm && (f_sel == 3'b100)) ? f_imm8 : rf[f_rs];
  assign op2 = f_imm ? f_imm8 : rf[f_rt];

  assign accept   = instr_valid & instr_ready;
  assign dbg_data = rf[dbg_addr];

  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) next_state = EXEC;
      end
      EXEC: next_state = DONE;
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      alu_op1 <= 8'h00;
      alu_op2 <= 8'h00;
      alu_sel <= 3'b000;
      rd_q    <= 2'b00;
      result  <= 8'h00;
      carry   <= 1'b0;
      for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
    end else begin
      state <= next_state;
      if (accept) begin
        alu_op1 <= op1;
        alu_op2 <= op2;
        alu_sel <= f_sel;
        rd_q    <= f_rd;
      end
      // Operands were read at accept, so rd aliasing rs/rt cannot hazard here.
      if (state == EXEC) begin
        rf[rd_q] <= alu_out;
        result   <= alu_out;
        carry    <= alu_co;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb/tb_alu_issue_unit.sv - Self-checking bench for alu_issue_unit.
// Transaction-level model plus directed literal checks and randomized traffic.
module tb_alu_issue_unit;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  alu_op1;
  logic [7:0]  alu_op2;
  logic [2:0]  alu_sel;
  logic [7:0]  alu_out;
  logic        alu_co;
  logic        done;
  logic [7:0]  result;
  logic        carry;
  logic [1:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int tests = 0;
  int fails = 0;

  alu_issue_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_sel     (alu_sel),
    .alu_out     (alu_out),
    .alu_co      (alu_co),
    .done        (done),
    .result      (result),
    .carry       (carry),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Downstream ALU: bit 8 is carry/borrow/shifted-out bit
  function automatic logic [8:0] alu_fn(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {1'b0, a} - {1'b0, b};
      3'd2: return {1'b0, ~(a ^ b)};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a & b};
      3'd5: return {1'b0, a ^ b};
      3'd6: return {a, 1'b0};
      default: return {1'b0, b};
    endcase
  endfunction

  logic [8:0] alu_res;
  assign alu_res = alu_fn(alu_sel, alu_op1, alu_op2);
  assign alu_out = alu_res[7:0];
  assign alu_co  = alu_res[8];

  function automatic logic [15:0] mk(input logic [2:0] s, input logic [1:0] rd, input logic [1:0] rs,
                                     input logic imm, input logic [7:0] lo);
    return {s, rd, rs, imm, lo};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: busy counts cycles left before ready returns
  logic [7:0] m_reg [4];
  int         m_busy = 0;
  logic [7:0] m_op1, m_op2, m_res, m_result;
  logic [2:0] m_sel;
  logic [1:0] m_rd;
  logic       m_co, m_carry;
  bit         m_live = 0;
  int         m_accepts = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
      m_busy = 0; m_op1 = 0; m_op2 = 0; m_sel = 0; m_result = 0; m_carry = 0;
      m_live = 1;
    end else if (m_live) begin
      if (m_busy == 0) begin
        if (instr_valid) begin
          logic [8:0] r;
          m_sel = instr[15:13];
          m_rd  = instr[12:11];
          m_op2 = instr[8] ? instr[7:0] : m_reg[instr[1:0]];
          m_op1 = (instr[8] && instr[15:13] == 3'b100) ? instr[7:0] : m_reg[instr[10:9]];
          r = alu_fn(m_sel, m_op1, m_op2);
          m_res = r[7:0];
          m_co  = r[8];
          m_busy = 2;
          m_accepts++;
        end
      end else if (m_busy == 2) begin
        m_reg[m_rd] = m_res;
        m_result = m_res;
        m_carry = m_co;
        m_busy = 1;
      end else begin
        m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("m_ready", instr_ready, m_busy == 0);
      check("m_done", done, m_busy == 1);
      check("m_op1", alu_op1, m_op1);
      check("m_op2", alu_op2, m_op2);
      check("m_sel", alu_sel, m_sel);
      check("m_result", result, m_result);
      check("m_carry", carry, m_carry);
      check("m_dbg", dbg_data, m_reg[dbg_addr]);
    end
  end

  task automatic run(input logic [15:0] ins, input logic [7:0] e1, input logic [7:0] e2,
                     input logic [1:0] rd, input logic [7:0] ev, input logic ec);
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("ready_wait", instr_ready, 1);
    instr = ins; instr_valid = 1'b1; dbg_addr = rd;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("exec_ready", instr_ready, 0);
    check("exec_done", done, 0);
    check("exec_op1", alu_op1, e1);
    check("exec_op2", alu_op2, e2);
    @(posedge clk); #1;
    check("done_pulse", done, 1);
    check("wb_reg", dbg_data, ev);
    check("wb_result", result, ev);
    check("wb_carry", carry, ec);
    @(posedge clk); #1;
    check("ready_back", instr_ready, 1);
    check("done_low", done, 0);
  endtask

  initial begin
    bit   prev_ready;
    bit   acc;
    int   last_rdy;
    rst = 1'b1; instr_valid = 1'b1; instr = mk(3'd4, 2'd3, 2'd0, 1'b1, 8'hAA); dbg_addr = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", instr_ready, 1);
    check("rst_done", done, 0);
    check("rst_carry", carry, 0);
    instr_valid = 1'b0;
    for (int a = 0; a < 4; a++) begin
      dbg_addr = a[1:0];
      #1;
      check("rst_dbg", dbg_data, 0);
    end
    @(posedge clk); #1;
    check("rst_no_accept", instr_ready, 1);

    run(mk(3'd4, 2'd0, 2'd0, 1'b1, 8'hF0), 8'hF0, 8'hF0, 2'd0, 8'hF0, 1'b0);
    run(mk(3'd4, 2'd1, 2'd0, 1'b1, 8'h20), 8'h20, 8'h20, 2'd1, 8'h20, 1'b0);
    run(mk(3'd0, 2'd2, 2'd0, 1'b0, 8'h01), 8'hF0, 8'h20, 2'd2, 8'h10, 1'b1);
    run(mk(3'd2, 2'd3, 2'd0, 1'b1, 8'h0F), 8'hF0, 8'h0F, 2'd3, 8'h00, 1'b0);
    run(mk(3'd0, 2'd1, 2'd1, 1'b0, 8'hFD), 8'h20, 8'h20, 2'd1, 8'h40, 1'b0);

    // Reset during EXEC of ADD rd=2
    dbg_addr = 2'd2;
    instr = mk(3'd0, 2'd2, 2'd0, 1'b0, 8'h01); instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("mid_exec", instr_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_ready", instr_ready, 1);
    check("mid_done", done, 0);
    check("mid_carry", carry, 0);
    check("mid_r2", dbg_data, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("mid_no_done", done, 0);
    end

    // Randomized traffic with a sustained-valid window
    prev_ready = instr_ready;
    last_rdy = -1;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      acc = instr_valid && prev_ready && !rst;
      if (i >= 100 && i < 140) begin
        rst = 1'b0;
        if (!instr_valid || acc) instr = 16'($urandom);
        instr_valid = 1'b1;
        if (instr_ready) begin
          if (last_rdy >= 0) check("bp_spacing", i - last_rdy, 3);
          last_rdy = i;
        end
      end else begin
        rst = ($urandom_range(0, 99) < 2);
        if (!instr_valid || acc) begin
          instr = 16'($urandom);
          instr_valid = ($urandom_range(0, 3) != 0);
        end
      end
      dbg_addr = 2'($urandom);
      prev_ready = instr_ready;
    end
    rst = 1'b0; instr_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("accepts_seen", m_accepts > 100, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
